// File: rtl/cic_pkg.sv
// cic_pkg: shared parameter limits and slice helper for the CIC decimator blocks
package cic_pkg;
  localparam int STAGES_MIN     = 1;
  localparam int STAGES_MAX     = 8;
  localparam int DIFF_DELAY_MIN = 1;
  localparam int DIFF_DELAY_MAX = 2;

  function automatic int out_slice_offset(input int w_inp, input int w_out);
    return w_inp - w_out;
  endfunction
endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: single comb y[n] = x[n] - x[n-DIFF_DELAY], advancing only on valid samples
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIFF_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);
  logic [DATA_WIDTH-1:0] r_dly [DIFF_DELAY];
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // fire on valid: subtract oldest history word and shift the delay line; clear/reset wipe everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dly   <= '{default: '0};
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_dly   <= '{default: '0};
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_valid) begin
      r_data  <= i_data - r_dly[DIFF_DELAY-1];
      r_dly[0] <= i_data;
      for (int i = 1; i < DIFF_DELAY; i++) r_dly[i] <= r_dly[i-1];
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/cic_comb_chain.sv
// cic_comb_chain: cascade of comb stages with truncating output slice
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH_INP = 32,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int STAGES         = 3,
  parameter int DIFF_DELAY     = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH_INP-1:0] s_axis_in_tdata,
  input  logic                      s_axis_in_tvalid,
  input  logic                      s_axis_clear,
  output logic [DATA_WIDTH_OUT-1:0] m_axis_out_tdata,
  output logic                      m_axis_out_tvalid
);
  localparam int OFF = out_slice_offset(DATA_WIDTH_INP, DATA_WIDTH_OUT);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("cic_comb_chain: STAGES out of range");
  end
  if (DIFF_DELAY < DIFF_DELAY_MIN || DIFF_DELAY > DIFF_DELAY_MAX) begin : g_bad_delay
    $error("cic_comb_chain: DIFF_DELAY out of range");
  end
  if (DATA_WIDTH_OUT > DATA_WIDTH_INP) begin : g_bad_width
    $error("cic_comb_chain: DATA_WIDTH_OUT exceeds DATA_WIDTH_INP");
  end

  logic [DATA_WIDTH_INP-1:0] w_data [STAGES+1];
  logic [STAGES:0]           w_valid;
  logic                      w_unused_lsbs;

  assign w_data[0]  = s_axis_in_tdata;
  assign w_valid[0] = s_axis_in_tvalid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cic_comb_stage #(
      .DATA_WIDTH (DATA_WIDTH_INP),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (s_axis_clear),
      .i_data  (w_data[k]),
      .i_valid (w_valid[k]),
      .o_data  (w_data[k+1]),
      .o_valid (w_valid[k+1])
    );
  end

  assign m_axis_out_tdata  = w_data[STAGES][OFF +: DATA_WIDTH_OUT];
  assign m_axis_out_tvalid = w_valid[STAGES];
  assign w_unused_lsbs     = ^w_data[STAGES];
endmodule

// File: tb/tb_cic_comb_chain.sv
// tb_cic_comb_chain: four comb chain configurations checked against a binomial-sum model
module tb_cic_comb_chain;
  localparam int ND = 4;
  localparam int N  = 4096;
  localparam int SP [ND] = '{3, 1, 3, 3};
  localparam int MP [ND] = '{1, 1, 2, 1};
  localparam int WI [ND] = '{16, 16, 16, 32};
  localparam int WO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] din = '0;
  logic        vin = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] od [ND];
  logic        ov [ND];

  int n_tests = 0;
  int n_fail  = 0;

  bit          acc [N];
  bit          cle [N];
  int          sidx [N];
  int          estart [N];
  logic [31:0] samp [N];
  int          e = 0;
  int          nsamp = 0;
  int          ep = 0;

  always #5 clk = ~clk;

  cic_comb_chain #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .STAGES(3), .DIFF_DELAY(1)) d0 (
    .clk(clk), .reset_n(reset_n), .s_axis_in_tdata(din[15:0]), .s_axis_in_tvalid(vin),
    .s_axis_clear(clr), .m_axis_out_tdata(od[0]), .m_axis_out_tvalid(ov[0]));
  cic_comb_chain #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .STAGES(1), .DIFF_DELAY(1)) d1 (
    .clk(clk), .reset_n(reset_n), .s_axis_in_tdata(din[15:0]), .s_axis_in_tvalid(vin),
    .s_axis_clear(clr), .m_axis_out_tdata(od[1]), .m_axis_out_tvalid(ov[1]));
  cic_comb_chain #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .STAGES(3), .DIFF_DELAY(2)) d2 (
    .clk(clk), .reset_n(reset_n), .s_axis_in_tdata(din[15:0]), .s_axis_in_tvalid(vin),
    .s_axis_clear(clr), .m_axis_out_tdata(od[2]), .m_axis_out_tvalid(ov[2]));
  cic_comb_chain #(.DATA_WIDTH_INP(32), .DATA_WIDTH_OUT(16), .STAGES(3), .DIFF_DELAY(1)) d3 (
    .clk(clk), .reset_n(reset_n), .s_axis_in_tdata(din), .s_axis_in_tvalid(vin),
    .s_axis_clear(clr), .m_axis_out_tdata(od[3]), .m_axis_out_tvalid(ov[3]));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint sext(input logic [31:0] v, input int w);
    longint t = longint'(v) & ((64'sd1 <<< w) - 1);
    if (((t >> (w - 1)) & 1) != 0) t -= (64'sd1 <<< w);
    return t;
  endfunction

  // comb cascade of order S with lag M equals sum_j (-1)^j C(S,j) x[n-jM], zero before the last clear
  function automatic longint model_out(input int i, input int k);
    longint s = 0;
    int idx;
    for (int j = 0; j <= SP[i]; j++) begin
      idx = sidx[k] - j * MP[i];
      if (idx >= estart[k]) s += ((j % 2) ? -binom(SP[i], j) : binom(SP[i], j)) * sext(samp[idx], WI[i]);
    end
    s = s & ((64'sd1 <<< WI[i]) - 1);
    return (s >> (WI[i] - WO)) & ((64'sd1 <<< WO) - 1);
  endfunction

  task automatic check_edge();
    int  k;
    bit  ev;
    for (int i = 0; i < ND; i++) begin
      k  = e - SP[i] + 1;
      ev = (k >= 0) && acc[k];
      for (int q = k + 1; q <= e; q++) if (q >= 0 && cle[q]) ev = 1'b0;
      chk($sformatf("d%0d_valid", i), longint'(ov[i]), longint'(ev));
      if (ev) chk($sformatf("d%0d_data", i), longint'(od[i]), model_out(i, k));
      if (cle[e]) chk($sformatf("d%0d_cleared_data", i), longint'(od[i]), 0);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit c, input bit rst);
    @(negedge clk);
    vin = v;
    din = d;
    clr = c;
    reset_n = !rst;
    if (rst) begin
      #1;
      for (int i = 0; i < ND; i++) begin
        chk($sformatf("d%0d_rst_data", i), longint'(od[i]), 0);
        chk($sformatf("d%0d_rst_valid", i), longint'(ov[i]), 0);
      end
    end
    cle[e] = c || rst;
    acc[e] = v && !cle[e];
    if (cle[e]) ep = nsamp;
    if (acc[e]) begin
      samp[nsamp] = d;
      sidx[e]     = nsamp;
      estart[e]   = ep;
      nsamp++;
    end
    @(posedge clk);
    #1;
    check_edge();
    e++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'd5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'd32767, 1'b0, 1'b0);
    step(1'b1, 32'hffff_8000, 1'b0, 1'b0);
    idle(4);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 0) ? 32'd1 : 32'd0, 1'b0, 1'b0);
      idle(2);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'd100, 1'b0, 1'b0);
    step(1'b1, 32'd200, 1'b0, 1'b0);
    step(1'b1, 32'd300, 1'b0, 1'b0);
    step(1'b1, 32'd400, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 32'd7, 1'b0, 1'b0);
    idle(5);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0001_8000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, '0, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, $urandom, ($urandom % 50) == 0, ($urandom % 200) == 0);
    idle(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
